io_out_fifo_fl: RTL and testbench
=================================

Name: io_out_fifo_fl

Overview:
- Output-side buffer placed directly downstream of the float processor core.
- Captures each single-cycle output write (data word plus output port address, qualified by out_en) into a FIFO.
- Presents the oldest entry to an external peripheral over a valid/ready handshake.
- The core cannot stall, so the block never back-pressures it. Writes arriving when the FIFO is full are dropped and flagged in a sticky overflow bit.

Parameters:
- NBMANT, 16, mantissa bits of the float word
- NBEXPO, 6, exponent bits; data word width is NBMANT+NBEXPO+1
- NUIOOU, 8, number of output addresses; address width is $clog2(NUIOOU)
- FDEPTH, 8, FIFO entries; must be a power of 2, ≥2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- out_en  in  1  core output strobe; one-cycle pulse per write
- data_in  in  NBMANT+NBEXPO+1  core data_out, sampled when out_en=1
- addr_in  in  $clog2(NUIOOU)  core addr_out, sampled when out_en=1
- m_valid  out  1  head entry available
- m_data  out  NBMANT+NBEXPO+1  head entry data
- m_addr  out  $clog2(NUIOOU)  head entry port address
- m_ready  in  1  peripheral accepts head entry
- flush  in  1  synchronous clear of FIFO contents
- ovf_clr  in  1  clears sticky overflow
- ovf  out  1  sticky: at least one write was dropped
- count  out  $clog2(FDEPTH)+1  current occupancy

Behaviour:
- Reset values: rd_ptr=0, wr_ptr=0, count=0, m_valid=0, ovf=0. m_data/m_addr read 0 after reset because the storage is cleared on reset.
- Definitions:
  - push = out_en & (count<FDEPTH | pop)
  - pop = m_valid & m_ready
  - drop = out_en & ~push
- Storage: FDEPTH entries of {addr,data}. The write port is registered. The read port is combinational from rd_ptr (first-word fall-through).
- Latency: an entry pushed at edge N is visible on m_valid/m_data/m_addr immediately after edge N (1 cycle from out_en to m_valid). No bypass path within the same cycle.
- m_valid = (count!=0). It is derived from count, which is a register.
- On pop: rd_ptr increments modulo FDEPTH and count decrements, unless a push occurs in the same cycle.
- Simultaneous push and pop:
  - count is unchanged.
  - Both pointers advance.
  - This also applies when full, so a full FIFO with m_ready=1 accepts the new write without dropping it.
- Pointers wrap naturally at FDEPTH. count saturates logically at FDEPTH; it never exceeds FDEPTH or underflows.
- Data stability: m_data/m_addr stay constant while m_valid=1 and m_ready=0. Peripherals may hold m_ready high permanently.
- Overflow: drop sets ovf on the next edge.
- ovf_clr, when asserted, clears ovf. If ovf_clr and drop occur in the same cycle, ovf ends at 1 (set wins).
- flush:
  - Pointers and count go to 0 on the next edge.
  - A push or pop in the same cycle is discarded (flush wins).
  - ovf is unaffected by flush.
- Asynchronous reset mid-transfer abandons all contents. No partial entry survives.
- ovf/count are registered outputs. m_valid depends only on registers; there is no combinational path from m_ready to m_valid.

Decomposition:
- Shared package io_fl_pkg holds:
  - localparams NBWORD = NBMANT+NBEXPO+1 and NBADDO = $clog2(NUIOOU)
  - the packed entry typedef {addr,data}
- One natural sub-module: fifo_mem_fl, a simple dual-port register array with a registered write and an asynchronous read, parameterised by width and depth.
- Pointer/count/ovf control stays in io_out_fifo_fl.

Test Plan:
- Reset then idle → m_valid=0, count=0, ovf=0. Pulse out_en with data_in=23'h012345, addr_in=3 → next cycle m_valid=1, m_data=23'h012345, m_addr=3, count=1.
- Push 8 words 1..8 with m_ready=0 → count=8. A 9th out_en (data 9) → ovf=1, count=8. Then drain with m_ready=1 → 1..8 emerge in order; 9 never appears.
- FIFO full, m_ready=1 and out_en=1 in the same cycle with data 23'h7FFFFF → count stays 8, no ovf, and the new word appears last in the drain.
- Continuous out_en every cycle with m_ready=1 for 20 cycles → count holds at 1 after the first edge, all 20 words appear in order, and pointer wrap is exercised.
- m_ready toggled pseudo-randomly while pushing 50 words → scoreboard matches order, m_data stable while stalled, ovf=0 provided occupancy never exceeds 8.
- Occupancy 3 with flush=1 and out_en=1 in the same cycle → count=0, m_valid=0, ovf unchanged. Assert ovf_clr and drop together → ovf=1. Assert rst mid-drain → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/io_fl_pkg.sv
// Shared word format for the float core output path: data/address widths and the FIFO entry.
package io_fl_pkg;

  localparam int unsigned NBMANT = 16;
  localparam int unsigned NBEXPO = 6;
  localparam int unsigned NUIOOU = 8;
  localparam int unsigned NBWORD = NBMANT + NBEXPO + 1;
  localparam int unsigned NBADDO = $clog2(NUIOOU);

  typedef struct packed {
    logic [NBADDO-1:0] addr;
    logic [NBWORD-1:0] data;
  } entry_t;

endpackage

// File: rtl/io_fl_if.sv
// Core-write / peripheral-read bundle of the output FIFO, plus its flush and overflow controls.
interface io_fl_if #(
   parameter int unsigned FDEPTH = 8
);
   import io_fl_pkg::*;

   logic                      out_en;
   logic [NBWORD-1:0]         data_in;
   logic [NBADDO-1:0]         addr_in;
   logic                      m_valid;
   logic [NBWORD-1:0]         m_data;
   logic [NBADDO-1:0]         m_addr;
   logic                      m_ready;
   logic                      flush;
   logic                      ovf_clr;
   logic                      ovf;
   logic [$clog2(FDEPTH):0]   count;

   // Driven by the core/peripheral side.
   modport master (
      output out_en, data_in, addr_in, m_ready, flush, ovf_clr,
      input  m_valid, m_data, m_addr, ovf, count
   );

   // Implemented by the FIFO.
   modport slave (
      input  out_en, data_in, addr_in, m_ready, flush, ovf_clr,
      output m_valid, m_data, m_addr, ovf, count
   );
endinterface

// File: rtl/fifo_mem_fl.sv
// Register-array storage: registered write port, combinational read port, cleared on reset.
module fifo_mem_fl #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8,
   localparam int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];

   always_comb begin
      mem_d = mem_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/io_out_fifo_fl.sv
// First-word fall-through output FIFO behind the float core; never stalls the core, drops
// writes when full and records that in a sticky overflow flag.
module io_out_fifo_fl
   import io_fl_pkg::*;
#(
   parameter int unsigned FDEPTH = 8  // power of two, >= 2
) (
   input  logic   clk,
   input  logic   rst,
   io_fl_if.slave bus
);

   localparam int unsigned PtrW = $clog2(FDEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            push, pop, drop, not_empty;
   entry_t          wr_entry, rd_entry;

   assign not_empty = (count_q != '0);
   assign wr_entry  = '{addr: bus.addr_in, data: bus.data_in};

   always_comb begin
      pop  = not_empty & bus.m_ready;
      // A full FIFO still takes a write when the head leaves in the same cycle.
      push = bus.out_en & ((count_q < CntW'(FDEPTH)) | pop);
      drop = bus.out_en & ~push;

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push) - CntW'(pop);
      end

      // Set beats clear; flush leaves the flag alone.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   fifo_mem_fl #(
      .Width ($bits(entry_t)),
      .Depth (FDEPTH)
   ) u_mem (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (push & ~bus.flush),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   assign bus.m_valid = not_empty;
   assign bus.m_data  = rd_entry.data;
   assign bus.m_addr  = rd_entry.addr;
   assign bus.ovf     = ovf_q;
   assign bus.count   = count_q;

endmodule

// File: tb/tb_io_out_fifo_fl.sv
// Directed and randomized checks of io_out_fifo_fl against a queue-based reference model.
module tb_io_out_fifo_fl;
   import io_fl_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   io_fl_if #(.FDEPTH(DEPTH)) bus ();

   io_out_fifo_fl #(.FDEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [NBADDO+NBWORD-1:0] q[$];
   logic                     m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_all();
      chk("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      if (q.size() != 0) begin
         chk("m_data", 32'(bus.m_data), 32'(q[0][NBWORD-1:0]));
         chk("m_addr", 32'(bus.m_addr), 32'(q[0][NBADDO+NBWORD-1:NBWORD]));
      end
   endtask

   // One clock: model the edge from the inputs currently driven, then compare.
   task automatic step();
      bit pop_m, drop_m;
      logic [NBADDO+NBWORD-1:0] ent;
      pop_m  = (q.size() != 0) && bus.m_ready;
      drop_m = bus.out_en && !((q.size() < DEPTH) || pop_m);
      ent    = {bus.addr_in, bus.data_in};
      @(posedge clk);
      #1;
      if (bus.flush) begin
         q.delete();
      end else begin
         if (pop_m) void'(q.pop_front());
         if (bus.out_en && !drop_m) q.push_back(ent);
      end
      if (drop_m) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      check_all();
   endtask

   task automatic idle_inputs();
      bus.out_en  = 1'b0;
      bus.m_ready = 1'b0;
      bus.flush   = 1'b0;
      bus.ovf_clr = 1'b0;
   endtask

   task automatic write(input logic [NBWORD-1:0] d, input logic [NBADDO-1:0] a);
      bus.out_en  = 1'b1;
      bus.data_in = d;
      bus.addr_in = a;
      step();
      bus.out_en  = 1'b0;
   endtask

   task automatic drain();
      bus.m_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step();
      bus.m_ready = 1'b0;
   endtask

   initial begin
      int pushed;
      idle_inputs();
      bus.data_in = '0;
      bus.addr_in = '0;

      // Reset then idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_all();
      chk("m_data_rst", 32'(bus.m_data), 32'd0);
      chk("m_addr_rst", 32'(bus.m_addr), 32'd0);
      step();

      // Single write, one-cycle fall-through
      write(23'h012345, 3'd3);
      chk("first_data", 32'(bus.m_data), 32'h012345);
      drain();

      // Fill, overflow on 9th, drain in order
      for (int i = 1; i <= 8; i++) write(NBWORD'(i), NBADDO'(i));
      chk("full_count", 32'(bus.count), 32'd8);
      write(NBWORD'(9), 3'd1);
      chk("ovf_set", 32'(bus.ovf), 32'd1);
      drain();
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(bus.ovf), 32'd0);

      // Full with simultaneous push and pop
      for (int i = 1; i <= 8; i++) write(NBWORD'(i + 16), NBADDO'(i));
      bus.m_ready = 1'b1;
      write(23'h7FFFFF, 3'd7);
      chk("full_pp_count", 32'(bus.count), 32'd8);
      drain();

      // Streaming with permanent ready, exercises pointer wrap
      bus.m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         write(NBWORD'($urandom), NBADDO'($urandom));
         bus.out_en = 1'b0;
      end
      drain();

      // Random ready with random writes; never write into a full FIFO
      pushed = 0;
      for (int cyc = 0; cyc < 400 && pushed < 50; cyc++) begin
         bus.m_ready = 1'($urandom);
         bus.out_en  = (q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
         bus.data_in = NBWORD'($urandom);
         bus.addr_in = NBADDO'($urandom);
         if (bus.out_en) pushed++;
         step();
      end
      bus.out_en = 1'b0;
      chk("random_pushed", 32'(pushed), 32'd50);
      drain();

      // Flush with concurrent write
      for (int i = 0; i < 3; i++) write(NBWORD'($urandom), NBADDO'($urandom));
      bus.flush  = 1'b1;
      bus.out_en = 1'b1;
      step();
      idle_inputs();
      chk("flush_count", 32'(bus.count), 32'd0);

      // Clear and drop together: set wins
      for (int i = 0; i < 8; i++) write(NBWORD'(i + 100), NBADDO'(i));
      bus.ovf_clr = 1'b1;
      write(NBWORD'(999), 3'd0);
      bus.ovf_clr = 1'b0;
      chk("ovf_set_wins", 32'(bus.ovf), 32'd1);

      // Asynchronous reset mid-drain
      bus.m_ready = 1'b1;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      q.delete();
      m_ovf = 1'b0;
      check_all();
      chk("m_data_arst", 32'(bus.m_data), 32'd0);
      chk("m_addr_arst", 32'(bus.m_addr), 32'd0);
      idle_inputs();
      @(posedge clk);
      #1 rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
